// File: rtl/snake_body_engine.sv
// ---------------------------------------------------------------------------
// snake_body_engine
//
// Game-state stage feeding the VGA controller. Holds the snake's segment grid
// coordinates, advances the head on each move tick, shifts the body (with
// optional growth), then scans the body one segment per cycle for a
// self-collision. Wall or self hits latch game over until reset.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   step       one-cycle move tick (honoured only in IDLE)
//   dir_in     requested direction: 0 up, 1 right, 2 down, 3 left
//   dir_valid  qualifies dir_in
//   grow       one-cycle pulse: grow on the next move
//   x_values   packed segment x, slot i at [i*COORD_W +: COORD_W], slot 0 = head
//   y_values   packed segment y, same packing
//   length     live segment count, 1..MAX_LEN
//   busy       high while in SHIFT or SCAN
//   step_done  one-cycle pulse when an accepted step completes
//   game_done  sticky game-over flag
// ---------------------------------------------------------------------------
module snake_body_engine #(
    parameter int MAX_LEN = 100,
    parameter int COORD_W = 32,
    parameter int GRID_W  = 10,
    parameter int GRID_H  = 10,
    parameter int START_X = 4,
    parameter int START_Y = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       step,
    input  logic [1:0]                 dir_in,
    input  logic                       dir_valid,
    input  logic                       grow,
    output logic [MAX_LEN*COORD_W-1:0] x_values,
    output logic [MAX_LEN*COORD_W-1:0] y_values,
    output logic [6:0]                 length,
    output logic                       busy,
    output logic                       step_done,
    output logic                       game_done
);

    typedef logic [COORD_W-1:0] coord_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_SCAN  = 2'd2;
    localparam logic [1:0] ST_DEAD  = 2'd3;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    // All-ones marks an unused slot; it can never match a legal head.
    localparam coord_t     SENTINEL  = '1;
    localparam coord_t     ZERO      = '0;
    localparam coord_t     ONE       = coord_t'(1);
    localparam coord_t     X_LAST    = coord_t'(GRID_W - 1);
    localparam coord_t     Y_LAST    = coord_t'(GRID_H - 1);
    localparam coord_t     X_START   = coord_t'(START_X);
    localparam coord_t     Y_START   = coord_t'(START_Y);
    localparam logic [6:0] MAX_LEN_L = 7'(MAX_LEN);

    coord_t     x_reg [MAX_LEN];
    coord_t     y_reg [MAX_LEN];
    coord_t     new_x_reg;
    coord_t     new_y_reg;
    logic [6:0] length_reg;
    logic [6:0] idx_reg;
    logic [1:0] state_reg;
    logic [1:0] dir_reg;
    logic       grow_pending_reg;
    logic       wall_done_reg;

    logic       reverse_req;
    logic       dir_accept;
    logic [1:0] dir_eff;
    logic       wall_hit;
    coord_t     cand_x;
    coord_t     cand_y;
    logic       scan_end;
    logic       scan_hit;
    logic       erase_tail;

    // A direct reversal would fold the head back into slot 1, so it is
    // refused once the body has more than one segment.
    assign reverse_req = dir_valid && (dir_in == (dir_reg ^ 2'd2)) && (length_reg > 7'd1);
    assign dir_accept  = dir_valid && !reverse_req && (state_reg != ST_DEAD);
    // A direction arriving together with step steers that very step.
    assign dir_eff     = dir_accept ? dir_in : dir_reg;

    always_comb begin
        wall_hit = 1'b0;
        cand_x   = x_reg[0];
        cand_y   = y_reg[0];
        case (dir_eff)
            DIR_UP: begin
                wall_hit = (y_reg[0] == ZERO);
                cand_y   = y_reg[0] - ONE;
            end
            DIR_RIGHT: begin
                wall_hit = (x_reg[0] == X_LAST);
                cand_x   = x_reg[0] + ONE;
            end
            DIR_DOWN: begin
                wall_hit = (y_reg[0] == Y_LAST);
                cand_y   = y_reg[0] + ONE;
            end
            default: begin
                wall_hit = (x_reg[0] == ZERO);
                cand_x   = x_reg[0] - ONE;
            end
        endcase
    end

    // idx_reg only indexes the arrays while it is below length_reg, so the
    // read stays inside the populated slots.
    assign scan_end = (state_reg == ST_SCAN) && (idx_reg >= length_reg);
    assign scan_hit = (state_reg == ST_SCAN) && !scan_end &&
                      (x_reg[idx_reg] == x_reg[0]) && (y_reg[idx_reg] == y_reg[0]);

    // Without growth the old tail, which the shift copies into slot[length],
    // must be wiped. At full length it simply falls off the end.
    assign erase_tail = !(grow_pending_reg && (length_reg < MAX_LEN_L)) &&
                        (length_reg < MAX_LEN_L);

    // Control path
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            dir_reg          <= DIR_RIGHT;
            grow_pending_reg <= 1'b0;
            length_reg       <= 7'd1;
            idx_reg          <= 7'd1;
            new_x_reg        <= X_START;
            new_y_reg        <= Y_START;
            wall_done_reg    <= 1'b0;
        end else begin
            wall_done_reg <= 1'b0;
            if (dir_accept) begin
                dir_reg <= dir_in;
            end
            case (state_reg)
                ST_IDLE: begin
                    grow_pending_reg <= grow_pending_reg | grow;
                    if (step) begin
                        if (wall_hit) begin
                            state_reg     <= ST_DEAD;
                            wall_done_reg <= 1'b1;
                        end else begin
                            new_x_reg <= cand_x;
                            new_y_reg <= cand_y;
                            state_reg <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (grow_pending_reg && (length_reg < MAX_LEN_L)) begin
                        length_reg <= length_reg + 7'd1;
                    end
                    // The pending request is consumed here; a pulse landing in
                    // this same cycle is held over for the next step.
                    grow_pending_reg <= grow;
                    idx_reg          <= 7'd1;
                    state_reg        <= ST_SCAN;
                end
                ST_SCAN: begin
                    grow_pending_reg <= grow_pending_reg | grow;
                    if (scan_end) begin
                        state_reg <= ST_IDLE;
                    end else if (scan_hit) begin
                        state_reg <= ST_DEAD;
                    end else begin
                        idx_reg <= idx_reg + 7'd1;
                    end
                end
                default: begin
                    state_reg <= ST_DEAD;
                end
            endcase
        end
    end

    // Segment storage: every slot moves in parallel during SHIFT, so these
    // are plain registers rather than a memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg[0] <= X_START;
            y_reg[0] <= Y_START;
            for (int i = 1; i < MAX_LEN; i++) begin
                x_reg[i] <= SENTINEL;
                y_reg[i] <= SENTINEL;
            end
        end else if (state_reg == ST_SHIFT) begin
            x_reg[0] <= new_x_reg;
            y_reg[0] <= new_y_reg;
            for (int i = 1; i < MAX_LEN; i++) begin
                if (erase_tail && (length_reg == 7'(i))) begin
                    x_reg[i] <= SENTINEL;
                    y_reg[i] <= SENTINEL;
                end else begin
                    x_reg[i] <= x_reg[i-1];
                    y_reg[i] <= y_reg[i-1];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_pack
            assign x_values[gi*COORD_W +: COORD_W] = x_reg[gi];
            assign y_values[gi*COORD_W +: COORD_W] = y_reg[gi];
        end
    endgenerate

    assign length    = length_reg;
    assign busy      = (state_reg == ST_SHIFT) || (state_reg == ST_SCAN);
    // The scan verdict is reported in the cycle it is reached; the wall
    // verdict is registered and shows in the cycle after the tick.
    assign step_done = wall_done_reg | scan_end | scan_hit;
    assign game_done = (state_reg == ST_DEAD) | scan_hit;

endmodule
